// File: rtl/cv32e40p_clic_pkg.sv
// Shared types and constants for the cv32e40p CLIC-lite interrupt controller.
package cv32e40p_clic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CLR  = 2'd2
  } clic_state_e;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  localparam int unsigned CLIC_PRIO_W = 3;

endpackage

// File: rtl/cv32e40p_clic_prio_tree.sv
// Combinational max-priority finder over NUM_IRQ (qual, prio) pairs.
// Equal priorities resolve to the higher source index.
module cv32e40p_clic_prio_tree
  import cv32e40p_clic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 32,
  parameter int unsigned PRIO_W  = CLIC_PRIO_W,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0]        qual_i,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio_i,
  output logic                      valid_o,
  output logic [ID_W-1:0]           id_o,
  output logic [PRIO_W-1:0]         prio_o
);

  // Ascending scan; '>=' lets a later index take over on an equal priority.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    prio_o  = '0;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      if (qual_i[k] && (!valid_o || (prio_i[k*PRIO_W +: PRIO_W] >= prio_o))) begin
        valid_o = 1'b1;
        id_o    = ID_W'(k);
        prio_o  = prio_i[k*PRIO_W +: PRIO_W];
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/cv32e40p_clic_lite.sv
// CLIC-lite: level/edge pendings, priority + threshold qualification, req/ack FSM.
// Optional NMI path is enabled by defining CV32E40P_CLIC_NMI_EN.
module cv32e40p_clic_lite
  import cv32e40p_clic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 32,
  parameter int unsigned PRIO_W  = CLIC_PRIO_W,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IRQ-1:0]        irq_i,
  input  logic [NUM_IRQ-1:0]        edge_mode_i,
  input  logic [NUM_IRQ-1:0]        ie_i,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0]         threshold_i,
  input  logic                      m_ie_i,
  output logic                      irq_req_o,
  output logic [ID_W-1:0]           irq_id_o,
  output logic [PRIO_W-1:0]         irq_prio_o,
  input  logic                      irq_ack_i,
  output logic [NUM_IRQ-1:0]        pending_o,
  output logic                      irq_wu_o
`ifdef CV32E40P_CLIC_NMI_EN
  ,
  input  logic                      nmi_i,
  output logic                      irq_nmi_o
`endif
);

  logic [NUM_IRQ-1:0] irq_q, irq_q2, mode_q;
  logic [NUM_IRQ-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_IRQ-1:0] pend_s, qual_s;
  clic_state_e        state_q, state_d;
  logic               req_q, req_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [PRIO_W-1:0]  prio_q, prio_d;
  logic               win_valid_s;
  logic [ID_W-1:0]    win_id_s;
  logic [PRIO_W-1:0]  win_prio_s;
  logic               ack_take_s;
  logic               nmi_pend_s;
  logic               nmi_lock_s;

  assign ack_take_s = (state_q == REQ) && irq_ack_i;

  // Per-source pending and qualification; a mode toggle drops any latched edge.
  always_comb begin
    pend_s      = '0;
    edge_pend_d = '0;
    qual_s      = '0;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      case (edge_mode_i[k])
        MODE_EDGE: begin
          pend_s[k]      = (edge_mode_i[k] == mode_q[k]) &&
                           (edge_pend_q[k] || (irq_q[k] && !irq_q2[k]));
          edge_pend_d[k] = (edge_mode_i[k] == mode_q[k]) &&
                           ((irq_q[k] && !irq_q2[k]) ||
                            (edge_pend_q[k] && !(ack_take_s && !nmi_lock_s &&
                                                 (id_q == ID_W'(k)))));
        end
        MODE_LEVEL: begin
          pend_s[k]      = irq_q[k];
          edge_pend_d[k] = 1'b0;
        end
        default: begin
          pend_s[k]      = 1'b0;
          edge_pend_d[k] = 1'b0;
        end
      endcase
      qual_s[k] = pend_s[k] && ie_i[k] && m_ie_i &&
                  (prio_i[k*PRIO_W +: PRIO_W] > threshold_i);
    end
  end

  cv32e40p_clic_prio_tree #(
    .NUM_IRQ (NUM_IRQ),
    .PRIO_W  (PRIO_W),
    .ID_W    (ID_W)
  ) u_prio_tree (
    .qual_i  (qual_s),
    .prio_i  (prio_i),
    .valid_o (win_valid_s),
    .id_o    (win_id_s),
    .prio_o  (win_prio_s)
  );

`ifdef CV32E40P_CLIC_NMI_EN
  logic nmi_q, nmi_q2, nmi_pend_q, nmi_pend_d, nmi_lock_q, nmi_lock_d;

  assign nmi_pend_s = nmi_pend_q || (nmi_q && !nmi_q2);
  assign nmi_pend_d = (nmi_q && !nmi_q2) || (nmi_pend_q && !(ack_take_s && nmi_lock_q));
  assign nmi_lock_d = (state_q == IDLE) ? nmi_pend_s : nmi_lock_q;
  assign nmi_lock_s = nmi_lock_q;
  assign irq_nmi_o  = nmi_lock_q && req_q;

  // NMI input stage and latched pending, independent of enables/threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_q      <= 1'b0;
      nmi_q2     <= 1'b0;
      nmi_pend_q <= 1'b0;
      nmi_lock_q <= 1'b0;
    end else begin
      nmi_q      <= nmi_i;
      nmi_q2     <= nmi_q;
      nmi_pend_q <= nmi_pend_d;
      nmi_lock_q <= nmi_lock_d;
    end
  end
`else
  assign nmi_pend_s = 1'b0;
  assign nmi_lock_s = 1'b0;
`endif

  // FSM state, output and source registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q       <= '0;
      irq_q2      <= '0;
      mode_q      <= '0;
      edge_pend_q <= '0;
      state_q     <= IDLE;
      req_q       <= 1'b0;
      id_q        <= '0;
      prio_q      <= '0;
    end else begin
      irq_q       <= irq_i;
      irq_q2      <= irq_q;
      mode_q      <= edge_mode_i;
      edge_pend_q <= edge_pend_d;
      state_q     <= state_d;
      req_q       <= req_d;
      id_q        <= id_d;
      prio_q      <= prio_d;
    end
  end

  // Next state: ack beats withdraw, a locked request is never preempted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (nmi_pend_s || win_valid_s) state_d = REQ;
        else                           state_d = IDLE;
      end
      REQ: begin
        if (irq_ack_i)                          state_d = CLR;
        else if (!nmi_lock_s && !qual_s[id_q])  state_d = IDLE;
        else                                    state_d = REQ;
      end
      CLR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values; id/prio are captured only when a request is launched.
  always_comb begin
    req_d  = 1'b0;
    id_d   = id_q;
    prio_d = prio_q;
    case (state_q)
      IDLE: begin
        if (nmi_pend_s) begin
          req_d  = 1'b1;
          id_d   = '0;
          prio_d = {PRIO_W{1'b1}};
        end else if (win_valid_s) begin
          req_d  = 1'b1;
          id_d   = win_id_s;
          prio_d = win_prio_s;
        end else begin
          req_d  = 1'b0;
        end
      end
      REQ:     req_d = (state_d == REQ);
      CLR:     req_d = 1'b0;
      default: req_d = 1'b0;
    endcase
  end

  assign irq_req_o  = req_q;
  assign irq_id_o   = id_q;
  assign irq_prio_o = prio_q;
  assign pending_o  = pend_s;
  assign irq_wu_o   = |(irq_i & ie_i);

endmodule

// File: tb/tb_cv32e40p_clic_lite.sv
// Self-checking bench for cv32e40p_clic_lite: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_cv32e40p_clic_lite;

  localparam int N  = 32;
  localparam int PW = 3;
  localparam int IW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    irq = '0, edge_mode = '0, ie = '0;
  logic [N*PW-1:0] prio = '0;
  logic [PW-1:0]   thr = '0;
  logic            m_ie = 1'b0, ack = 1'b0;
  logic            req_o, wu_o;
  logic [IW-1:0]   id_o;
  logic [PW-1:0]   prio_o;
  logic [N-1:0]    pend_o;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  cv32e40p_clic_lite dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_i       (irq),
    .edge_mode_i (edge_mode),
    .ie_i        (ie),
    .prio_i      (prio),
    .threshold_i (thr),
    .m_ie_i      (m_ie),
    .irq_req_o   (req_o),
    .irq_id_o    (id_o),
    .irq_prio_o  (prio_o),
    .irq_ack_i   (ack),
    .pending_o   (pend_o),
    .irq_wu_o    (wu_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0]  m_s1 = '0, m_s2 = '0, m_mode_prev = '0, m_lat = '0;
  logic          m_req = 1'b0, m_bubble = 1'b0;
  int            m_id = 0, m_prio = 0;

  function automatic int prio_of(input int k);
    return int'(prio[k*PW +: PW]);
  endfunction

  function automatic logic [N-1:0] model_pend();
    logic [N-1:0] p;
    for (int k = 0; k < N; k++) begin
      if (edge_mode[k])
        p[k] = (m_mode_prev[k] == 1'b1) && (m_lat[k] || (m_s1[k] && !m_s2[k]));
      else
        p[k] = m_s1[k];
    end
    return p;
  endfunction

  function automatic logic eligible(input int k, input logic [N-1:0] p);
    return p[k] && ie[k] && m_ie && (prio_of(k) > int'(thr));
  endfunction

  task automatic model_step();
    logic [N-1:0] p, nl;
    logic took;
    int best_p, best_id;
    p = model_pend();
    took = m_req && ack;
    for (int k = 0; k < N; k++)
      nl[k] = edge_mode[k] && (m_mode_prev[k] == 1'b1) &&
              ((m_s1[k] && !m_s2[k]) || (m_lat[k] && !(took && m_id == k)));
    best_p = -1;
    best_id = 0;
    for (int k = 0; k < N; k++)
      if (eligible(k, p) && prio_of(k) > best_p) best_p = prio_of(k);
    for (int k = 0; k < N; k++)
      if (eligible(k, p) && prio_of(k) == best_p) best_id = k;
    if (m_req) begin
      if (took) begin
        m_req <= 1'b0;
        m_bubble <= 1'b1;
      end else if (!eligible(m_id, p)) begin
        m_req <= 1'b0;
      end
    end else if (m_bubble) begin
      m_bubble <= 1'b0;
    end else if (best_p >= 0) begin
      m_req  <= 1'b1;
      m_id   <= best_id;
      m_prio <= best_p;
    end
    m_lat <= nl;
    m_s2 <= m_s1;
    m_s1 <= irq;
    m_mode_prev <= edge_mode;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_mode_prev <= '0; m_lat <= '0;
      m_req <= 1'b0; m_bubble <= 1'b0; m_id <= 0; m_prio <= 0;
    end else begin
      model_step();
    end
  end

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("model_req", 64'(req_o), 64'(m_req));
      chk("model_id", 64'(id_o), 64'(m_id));
      chk("model_prio", 64'(prio_o), 64'(m_prio));
      chk("model_pending", 64'(pend_o), 64'(model_pend()));
      chk("model_wakeup", 64'(wu_o), 64'(|(irq & ie)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_prio(input int k, input int v);
    prio[k*PW +: PW] = PW'(v);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    ie = '1; m_ie = 1'b1;
    ticks(3);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();
    chk("reset_req", 64'(req_o), 64'd0);
    chk("reset_id", 64'(id_o), 64'd0);
    chk("reset_prio", 64'(prio_o), 64'd0);
    chk("reset_pending", 64'(pend_o), 64'd0);

    // Level source 5: request two cycles after assertion, withdraw on deassert.
    set_prio(5, 3);
    irq[5] = 1'b1;
    ticks(2);
    chk("lvl5_req", 64'(req_o), 64'd1);
    chk("lvl5_id", 64'(id_o), 64'd5);
    chk("lvl5_prio", 64'(prio_o), 64'd3);
    irq[5] = 1'b0;
    tick();
    chk("lvl5_still_req", 64'(req_o), 64'd1);
    tick();
    chk("lvl5_withdraw", 64'(req_o), 64'd0);
    chk("lvl5_pend_clr", 64'(pend_o[5]), 64'd0);
    set_prio(5, 0);

    // Edge source 2: single pulse latched until ack.
    edge_mode[2] = 1'b1;
    set_prio(2, 4);
    ticks(2);
    irq[2] = 1'b1;
    tick();
    irq[2] = 1'b0;
    tick();
    chk("edge2_req", 64'(req_o), 64'd1);
    chk("edge2_id", 64'(id_o), 64'd2);
    ticks(4);
    chk("edge2_held_pend", 64'(pend_o[2]), 64'd1);
    chk("edge2_held_req", 64'(req_o), 64'd1);
    do_ack();
    chk("edge2_ack_req", 64'(req_o), 64'd0);
    chk("edge2_ack_pend", 64'(pend_o[2]), 64'd0);
    ticks(4);
    chk("edge2_no_rereq", 64'(req_o), 64'd0);
    set_prio(2, 0);

    // Edge sources 4 (prio 2) and 9 (prio 6): 9 first, then 4 two cycles after ack.
    edge_mode[4] = 1'b1; edge_mode[9] = 1'b1;
    set_prio(4, 2); set_prio(9, 6);
    ticks(2);
    irq[4] = 1'b1; irq[9] = 1'b1;
    tick();
    irq[4] = 1'b0; irq[9] = 1'b0;
    tick();
    chk("arb_id9", 64'(id_o), 64'd9);
    chk("arb_prio6", 64'(prio_o), 64'd6);
    do_ack();
    chk("arb_bubble0", 64'(req_o), 64'd0);
    tick();
    chk("arb_bubble1", 64'(req_o), 64'd0);
    tick();
    chk("arb_req4", 64'(req_o), 64'd1);
    chk("arb_id4", 64'(id_o), 64'd4);
    do_ack();
    ticks(2);
    chk("arb_drained", 64'(pend_o), 64'd0);
    set_prio(4, 0); set_prio(9, 0);

    // Tie at prio 5 between level sources 3 and 7.
    set_prio(3, 5); set_prio(7, 5);
    irq[3] = 1'b1; irq[7] = 1'b1;
    ticks(2);
    chk("tie_id7", 64'(id_o), 64'd7);
    irq[3] = 1'b0; irq[7] = 1'b0;
    ticks(2);
    chk("tie_withdraw", 64'(req_o), 64'd0);
    set_prio(3, 0); set_prio(7, 0);

    // Threshold: prio must be strictly above it.
    set_prio(1, 4); thr = 3'd4;
    irq[1] = 1'b1;
    ticks(4);
    chk("thr_blocked", 64'(req_o), 64'd0);
    thr = 3'd3;
    tick();
    chk("thr_req", 64'(req_o), 64'd1);
    chk("thr_id1", 64'(id_o), 64'd1);
    thr = 3'd4;
    tick();
    chk("thr_withdraw", 64'(req_o), 64'd0);
    irq[1] = 1'b0; thr = 3'd0; set_prio(1, 0);
    ticks(2);

    // Edge source 6 re-pulses in the ack cycle: set wins, new req two cycles later.
    edge_mode[6] = 1'b1; set_prio(6, 5);
    ticks(2);
    irq[6] = 1'b1;
    tick();
    irq[6] = 1'b0;
    tick();
    chk("re6_req", 64'(req_o), 64'd1);
    chk("re6_id", 64'(id_o), 64'd6);
    irq[6] = 1'b1;
    tick();
    irq[6] = 1'b0;
    do_ack();
    chk("re6_ack_req", 64'(req_o), 64'd0);
    chk("re6_pend_kept", 64'(pend_o[6]), 64'd1);
    tick();
    chk("re6_bubble", 64'(req_o), 64'd0);
    tick();
    chk("re6_rereq", 64'(req_o), 64'd1);
    chk("re6_reid", 64'(id_o), 64'd6);

    // Asynchronous reset while a request is up.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 64'(req_o), 64'd0);
    chk("arst_id", 64'(id_o), 64'd0);
    chk("arst_prio", 64'(prio_o), 64'd0);
    chk("arst_pending", 64'(pend_o), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      irq = irq ^ ($urandom() & $urandom() & $urandom());
      ack = ($urandom_range(0, 3) == 0);
      if (i % 64 == 0)  prio = {$urandom(), $urandom(), $urandom()};
      if (i % 50 == 0)  ie = ~($urandom() & $urandom() & $urandom());
      if (i % 40 == 0)  thr = PW'($urandom_range(0, 3));
      if (i % 30 == 0)  m_ie = ($urandom_range(0, 5) != 0);
      if (i % 100 == 0) edge_mode[$urandom_range(0, N-1)] ^= 1'b1;
      if (i == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rand_arst_req", 64'(req_o), 64'd0);
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    ack = 1'b0;
    ticks(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
